// File: rtl/sensor_emul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sensor_emul_pkg
// Brief    : State codes and shared defaults for the HC-SR04 echo emulator
// Revision : 1.0 - initial release
// ============================================================================
package sensor_emul_pkg;

    typedef enum logic [3:0] {
        ST_OCIOSA       = 4'd0,
        ST_MEDE_TRIGGER = 4'd1,
        ST_ESPERA_BURST = 4'd2,
        ST_ECO          = 4'd3,
        ST_SEM_ECO      = 4'd4,
        ST_RECUPERA     = 4'd5
    } estado_t;

    localparam int DEF_CYCLES_PER_CM = 2941;
    localparam int DEF_MAX_CM        = 400;
    localparam int DIST_W            = 9;

    function automatic int cnt_width(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/contador_m.sv
`default_nettype none
// ============================================================================
// Module   : contador_m
// Brief    : Modulo-M counter with enable, synchronous clear and end-of-count
// Revision : 1.0 - initial release
// ============================================================================
module contador_m
    import sensor_emul_pkg::*;
#(
    parameter int M = 10,
    parameter int W = cnt_width(M)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         enable_i,
    output logic [W-1:0] count_o,
    output logic         fim_o
);

    localparam logic [W-1:0] LAST = W'(M - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign fim_o   = (count_q == LAST);

endmodule
`default_nettype wire

// File: rtl/sensor_echo_emulator.sv
`default_nettype none
// ============================================================================
// Module   : sensor_echo_emulator
// Brief    : HC-SR04 responder: validates trigger, waits burst delay, then
//            drives echo for distance x CYCLES_PER_CM cycles
// Revision : 1.0 - initial release
// ============================================================================
module sensor_echo_emulator
    import sensor_emul_pkg::*;
#(
    parameter int CYCLES_PER_CM     = DEF_CYCLES_PER_CM,
    parameter int TRIG_MIN_CYCLES   = 500,
    parameter int ECHO_DELAY_CYCLES = 10000,
    parameter int MAX_CM            = DEF_MAX_CM,
    parameter int NO_ECHO_CYCLES    = 1500000,
    parameter int HOLDOFF_CYCLES    = 500
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              habilita,
    input  logic              trigger,
    input  logic [DIST_W-1:0] distancia,
    output logic              echo,
    output logic              ocupado,
    output logic              medida_fim,
    output logic [3:0]        db_estado
);

    localparam logic [DIST_W-1:0] MAX_CM_V = DIST_W'(MAX_CM);
    localparam int TRIG_M  = TRIG_MIN_CYCLES + 1;
    localparam int CM_M    = 1 << DIST_W;

    estado_t             estado_q;
    estado_t             estado_d;
    logic                trig_prev_q;
    logic [DIST_W-1:0]   dist_q;
    logic                echo_q;
    logic                ocupado_q;
    logic                medida_fim_q;
    logic [3:0]          db_estado_q;

    logic                w_trig_rise;
    logic                w_trig_sat;
    logic                w_delay_fim;
    logic                w_window_fim;
    logic                w_holdoff_fim;
    logic                w_sub_fim;
    logic [DIST_W-1:0]   w_cm_count;
    logic                w_dist_ok;
    logic                w_eco_fim;
    logic                w_in_mede;
    logic                w_in_eco;

    logic [cnt_width(TRIG_M)-1:0]            w_trig_cnt_unused;
    logic [cnt_width(ECHO_DELAY_CYCLES)-1:0] w_delay_cnt_unused;
    logic [cnt_width(NO_ECHO_CYCLES)-1:0]    w_window_cnt_unused;
    logic [cnt_width(HOLDOFF_CYCLES)-1:0]    w_holdoff_cnt_unused;
    logic [cnt_width(CYCLES_PER_CM)-1:0]     w_sub_cnt_unused;
    logic                                    w_cm_wrap_unused;

    assign w_in_mede   = (estado_q == ST_MEDE_TRIGGER);
    assign w_in_eco    = (estado_q == ST_ECO);
    // A trigger already high on entry to idle leaves trig_prev_q set, so it is not an edge
    assign w_trig_rise = (estado_q == ST_OCIOSA) && habilita && trigger && !trig_prev_q;
    assign w_dist_ok   = (dist_q != '0) && (dist_q <= MAX_CM_V);
    assign w_eco_fim   = w_sub_fim && (w_cm_count == dist_q - DIST_W'(1));

    // Saturates at TRIG_MIN_CYCLES; loaded to 1 on the accepting edge
    contador_m #(.M(TRIG_M)) u_trig (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (!w_in_mede && !w_trig_rise),
        .enable_i (w_trig_rise || (w_in_mede && trigger && !w_trig_sat)),
        .count_o  (w_trig_cnt_unused),
        .fim_o    (w_trig_sat)
    );

    contador_m #(.M(ECHO_DELAY_CYCLES)) u_delay (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (estado_q != ST_ESPERA_BURST),
        .enable_i (estado_q == ST_ESPERA_BURST),
        .count_o  (w_delay_cnt_unused),
        .fim_o    (w_delay_fim)
    );

    contador_m #(.M(NO_ECHO_CYCLES)) u_window (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (estado_q != ST_SEM_ECO),
        .enable_i (estado_q == ST_SEM_ECO),
        .count_o  (w_window_cnt_unused),
        .fim_o    (w_window_fim)
    );

    contador_m #(.M(HOLDOFF_CYCLES)) u_holdoff (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (estado_q != ST_RECUPERA),
        .enable_i (estado_q == ST_RECUPERA),
        .count_o  (w_holdoff_cnt_unused),
        .fim_o    (w_holdoff_fim)
    );

    // Echo length is cm x sub-count, so no multiplier is needed
    contador_m #(.M(CYCLES_PER_CM)) u_sub (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (!w_in_eco),
        .enable_i (w_in_eco),
        .count_o  (w_sub_cnt_unused),
        .fim_o    (w_sub_fim)
    );

    contador_m #(.M(CM_M)) u_cm (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (!w_in_eco),
        .enable_i (w_in_eco && w_sub_fim),
        .count_o  (w_cm_count),
        .fim_o    (w_cm_wrap_unused)
    );

    always_comb begin
        estado_d = estado_q;
        if (!habilita) begin
            estado_d = ST_OCIOSA;
        end else begin
            case (estado_q)
                ST_OCIOSA:       if (w_trig_rise)   estado_d = ST_MEDE_TRIGGER;
                ST_MEDE_TRIGGER: if (!trigger)      estado_d = w_trig_sat ? ST_ESPERA_BURST : ST_OCIOSA;
                ST_ESPERA_BURST: if (w_delay_fim)   estado_d = w_dist_ok ? ST_ECO : ST_SEM_ECO;
                ST_ECO:          if (w_eco_fim)     estado_d = ST_RECUPERA;
                ST_SEM_ECO:      if (w_window_fim)  estado_d = ST_RECUPERA;
                ST_RECUPERA:     if (w_holdoff_fim) estado_d = ST_OCIOSA;
                default:                            estado_d = ST_OCIOSA;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q     <= ST_OCIOSA;
            trig_prev_q  <= 1'b0;
            dist_q       <= '0;
            echo_q       <= 1'b0;
            ocupado_q    <= 1'b0;
            medida_fim_q <= 1'b0;
            db_estado_q  <= 4'd0;
        end else begin
            estado_q     <= estado_d;
            trig_prev_q  <= trigger;
            if (w_in_mede && (estado_d == ST_ESPERA_BURST)) begin
                dist_q <= distancia;
            end
            echo_q       <= (estado_d == ST_ECO);
            ocupado_q    <= (estado_d != ST_OCIOSA);
            // Recovery is only entered from eco/sem_eco, i.e. on a completed request
            medida_fim_q <= (estado_d == ST_RECUPERA) && (estado_q != ST_RECUPERA);
            db_estado_q  <= estado_d;
        end
    end

    assign echo       = echo_q;
    assign ocupado    = ocupado_q;
    assign medida_fim = medida_fim_q;
    assign db_estado  = db_estado_q;

endmodule
`default_nettype wire

// File: tb/tb_sensor_echo_emulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_sensor_echo_emulator
// Brief    : Scoreboard bench for sensor_echo_emulator with scaled timing
// Revision : 1.0 - initial release
// ============================================================================
module tb_sensor_echo_emulator;

    localparam int CPC    = 7;
    localparam int TMIN   = 5;
    localparam int DLY    = 20;
    localparam int MAXC   = 400;
    localparam int NOECHO = 300;
    localparam int HOLD   = 10;
    localparam int IDLE_LIMIT = DLY + NOECHO + MAXC * CPC + HOLD + 200;
    localparam int EV_ECHO = 0;
    localparam int EV_FIM  = 1;

    logic       clock     = 1'b0;
    logic       reset     = 1'b1;
    logic       habilita  = 1'b1;
    logic       trigger   = 1'b0;
    logic [8:0] distancia = 9'd0;
    logic       echo;
    logic       ocupado;
    logic       medida_fim;
    logic [3:0] db_estado;

    int cyc   = 0;
    int tests = 0;
    int fails = 0;

    typedef struct {
        int kind;
        int at;
        int width;
    } ev_t;
    ev_t exp_q[$];

    sensor_echo_emulator #(
        .CYCLES_PER_CM     (CPC),
        .TRIG_MIN_CYCLES   (TMIN),
        .ECHO_DELAY_CYCLES (DLY),
        .MAX_CM            (MAXC),
        .NO_ECHO_CYCLES    (NOECHO),
        .HOLDOFF_CYCLES    (HOLD)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .habilita   (habilita),
        .trigger    (trigger),
        .distancia  (distancia),
        .echo       (echo),
        .ocupado    (ocupado),
        .medida_fim (medida_fim),
        .db_estado  (db_estado)
    );

    initial forever #5 clock = ~clock;

    // cyc holds the number of the most recent rising edge
    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic void got_event(input int kind, input int at, input int width);
        ev_t e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, at);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cycle", at, e.at);
            if (kind == EV_ECHO) chk("echo_width", width, e.width);
        end
    endfunction

    // Monitor: echo pulses and medida_fim pulses, compared in order against the model queue
    initial begin
        logic echo_prev;
        int   rise_at;
        echo_prev = 1'b0;
        rise_at   = 0;
        forever begin
            @(negedge clock);
            if (echo && !echo_prev) rise_at = cyc;
            if (!echo && echo_prev) got_event(EV_ECHO, rise_at, cyc - rise_at);
            if (medida_fim) got_event(EV_FIM, cyc, 0);
            echo_prev = echo;
        end
    end

    // Reference: t0 is the edge where trigger first samples low after a valid run
    task automatic model_request(input int d, input int t0, output int fim_at);
        if (d >= 1 && d <= MAXC) begin
            exp_q.push_back('{EV_ECHO, t0 + DLY, d * CPC});
            fim_at = t0 + DLY + d * CPC;
        end else begin
            fim_at = t0 + DLY + NOECHO;
        end
        exp_q.push_back('{EV_FIM, fim_at, 0});
    endtask

    task automatic fire(input int d, input int h, output int t0, output int fim_at);
        distancia = 9'(d);
        trigger   = 1'b1;
        repeat (h) @(negedge clock);
        trigger = 1'b0;
        t0      = cyc + 1;
        fim_at  = -1;
        if (h >= TMIN) model_request(d, t0, fim_at);
        @(negedge clock);
        chk("state_after_trigger", db_estado, (h >= TMIN) ? 2 : 0);
        chk("ocupado_after_trigger", ocupado, (h >= TMIN) ? 1 : 0);
    endtask

    task automatic raw_pulse(input int h);
        trigger = 1'b1;
        repeat (h) @(negedge clock);
        trigger = 1'b0;
        @(negedge clock);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clock);
        while (db_estado != 4'd0 && n < IDLE_LIMIT) begin
            @(negedge clock);
            n++;
        end
        if (n >= IDLE_LIMIT) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: state %0d, expected 0 within %0d cycles", db_estado, IDLE_LIMIT);
        end
        @(negedge clock);
    endtask

    task automatic abort_eco(input bit use_reset, input int rise);
        if (use_reset) reset = 1'b1;
        else           habilita = 1'b0;
        exp_q.delete();
        exp_q.push_back('{EV_ECHO, rise, cyc + 1 - rise});
        @(negedge clock);
        chk("echo_after_abort", echo, 0);
        chk("state_after_abort", db_estado, 0);
        chk("ocupado_after_abort", ocupado, 0);
        chk("fim_after_abort", medida_fim, 0);
        reset    = 1'b0;
        habilita = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
        $fatal(1);
    end

    initial begin
        int t0;
        int fe;
        int fe2;

        repeat (3) @(negedge clock);
        chk("reset_echo", echo, 0);
        chk("reset_ocupado", ocupado, 0);
        chk("reset_fim", medida_fim, 0);
        chk("reset_state", db_estado, 0);
        reset = 1'b0;
        @(negedge clock);

        // Basic echo with long trigger
        fire(100, TMIN + 3, t0, fe);
        wait_idle();

        // Distance change during eco has no effect
        fire(75, TMIN + 1, t0, fe);
        wait_until(t0 + DLY + 30);
        chk("state_in_eco", db_estado, 3);
        distancia = 9'd100;
        wait_idle();

        // Short trigger rejected; exact minimum accepted
        fire(33, TMIN - 1, t0, fe);
        wait_idle();
        fire(1, TMIN, t0, fe);
        wait_idle();

        // Out-of-range distances and the inclusive upper bound
        fire(0, TMIN + 1, t0, fe);
        wait_idle();
        fire(450, TMIN + 1, t0, fe);
        wait_idle();
        fire(401, TMIN + 1, t0, fe);
        wait_idle();
        fire(400, TMIN + 1, t0, fe);
        wait_idle();

        // Triggers during eco and recupera are ignored; right after holdoff is accepted
        fire(20, TMIN + 2, t0, fe);
        wait_until(t0 + DLY + 50);
        raw_pulse(TMIN + 3);
        wait_until(fe + 2);
        chk("state_in_recupera", db_estado, 5);
        raw_pulse(3);
        wait_until(fe + HOLD);
        fire(5, TMIN + 1, t0, fe2);
        wait_until(fe2 + HOLD - 1);
        raw_pulse(TMIN + 2);
        chk("state_after_early_trigger", db_estado, 0);
        chk("ocupado_after_early_trigger", ocupado, 0);
        wait_idle();

        // Abort mid-echo via reset, then via habilita
        fire(50, TMIN + 1, t0, fe);
        wait_until(t0 + DLY + 40);
        abort_eco(1'b1, t0 + DLY);
        wait_until(fe + HOLD + 5);
        fire(60, TMIN + 1, t0, fe);
        wait_until(t0 + DLY + 77);
        abort_eco(1'b0, t0 + DLY);
        wait_until(fe + HOLD + 5);

        for (int i = 0; i < 20; i++) begin
            int d;
            int h;
            case ($urandom_range(0, 9))
                0:       d = 0;
                1:       d = int'($urandom_range(401, 511));
                default: d = int'($urandom_range(1, 60));
            endcase
            h = int'($urandom_range(1, TMIN + 4));
            repeat ($urandom_range(0, 3)) @(negedge clock);
            fire(d, h, t0, fe);
            if ($urandom_range(0, 3) == 0) distancia = 9'($urandom);
            wait_idle();
        end

        repeat (5) @(negedge clock);
        chk("pending_events", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sensor_echo_emulator.md
# sensor_echo_emulator

Synthesizable responder for the ultrasonic ranging interface: it plays the part of the HC-SR04 module that the game controller's distance-measurement path drives. It accepts the controller's `trigger` pulse, waits a fixed burst delay, then drives `echo` high for a time proportional to a programmable distance, at 58.82 us per cm. It sits on the board/bench side of the `trigger`/`echo` pins, so the controller's sensor path and timeout can be exercised without hardware.

## Interface
- `CYCLES_PER_CM`, 2941: clock cycles of echo per cm (58.82 us at 50 MHz).
- `TRIG_MIN_CYCLES`, 500: minimum trigger high run for a valid request (10 us).
- `ECHO_DELAY_CYCLES`, 10000: delay from trigger fall to echo rise (200 us).
- `MAX_CM`, 400: largest distance that produces an echo.
- `NO_ECHO_CYCLES`, 1500000: length of the silent window when there is no target (30 ms).
- `HOLDOFF_CYCLES`, 500: recovery time before a new trigger is accepted.
- `clock`, in, 1: system clock (50 MHz).
- `reset`, in, 1: synchronous, active-high.
- `habilita`, in, 1: emulator enable.
- `trigger`, in, 1: request pulse from the controller; same clock domain, no synchronizer.
- `distancia`, in, 9: distance in cm, unsigned.
- `echo`, out, 1: registered echo pulse.
- `ocupado`, out, 1: high in every state except `ociosa`.
- `medida_fim`, out, 1: one-cycle pulse at the end of each accepted request.
- `db_estado`, out, 4: current state code.

## Operation
- States and codes: `ociosa`=0, `mede_trigger`=1, `espera_burst`=2, `eco`=3, `sem_eco`=4, `recupera`=5.
- `ociosa`:
  - Leaves only on a rising edge of `trigger` (registered previous value 0, current 1) while `habilita`=1. Next state is `mede_trigger` with the high counter at 1.
  - A trigger already high when `ociosa` is entered is not a rising edge.
- `mede_trigger`: counts sampled-high cycles, saturating at `TRIG_MIN_CYCLES`. On the first cycle `trigger` samples 0:
  - count ≥ `TRIG_MIN_CYCLES`: latch `distancia` and go to `espera_burst`.
  - otherwise: go to `ociosa`; no `medida_fim`.
- `espera_burst`: counts `ECHO_DELAY_CYCLES`, then:
  - latched distance in 1..`MAX_CM`: go to `eco`.
  - otherwise (0 or > `MAX_CM`): go to `sem_eco`.
- `eco`:
  - `echo`=1.
  - A nested counter runs a cm count (9 bits) over a sub-count (12 bits, 0..`CYCLES_PER_CM`-1). No multiplier.
  - Ends after exactly distance × `CYCLES_PER_CM` cycles, then goes to `recupera` and pulses `medida_fim`.
- `sem_eco`: `echo`=0 for `NO_ECHO_CYCLES`, then goes to `recupera` and pulses `medida_fim`.
- `recupera`: lasts `HOLDOFF_CYCLES`, then goes to `ociosa`. Trigger activity in this state is ignored.
- Trigger edges are ignored in `espera_burst`, `eco`, `sem_eco` and `recupera`. A `distancia` change after the latch has no effect on the current request.
- `habilita` deasserted in any state: go to `ociosa` on the next edge, `echo`=0, no `medida_fim`.

## Timing
- Reset (synchronous): state `ociosa`, all counters 0, previous-trigger register 0, `echo`=0, `ocupado`=0, `medida_fim`=0, `db_estado`=0.
- Reset asserted mid-echo: `echo`=0 at the next edge.
- Let t0 be the edge at which `trigger` first samples 0 after a valid run:
  - `echo` rises at t0+`ECHO_DELAY_CYCLES`.
  - `echo` falls at t0+`ECHO_DELAY_CYCLES`+d×`CYCLES_PER_CM`.
  - `medida_fim` is high during the cycle after `echo` falls.
- The next trigger rising edge is accepted no earlier than `HOLDOFF_CYCLES`+1 cycles after `medida_fim`.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `sensor_emul_pkg`: state codes, default `CYCLES_PER_CM`, default `MAX_CM`.
- Sub-module `contador_m` (modulo-M counter with enable, clear and end-of-count flag). Instantiate it for the trigger-width, delay/window/holdoff and cm/sub-cm counters.
- The FSM stays in the top module.

## Test plan
- Scenario 1: `distancia`=100, trigger high 600 cycles -> `echo` high for exactly 294100 cycles (5882 us), rising 10000 cycles after trigger fall; one `medida_fim` pulse.
- Scenario 2: `distancia`=75 -> `echo` width 220575 cycles. `distancia` changed to 100 during `eco` -> width unchanged.
- Scenario 3: trigger high 400 cycles -> no echo, no `medida_fim`, `db_estado` back to 0.
- Scenario 4: `distancia`=0 (and separately 450) -> `echo` stays 0. `medida_fim` pulses 10000+1500000 cycles after trigger fall.
- Scenario 5: second trigger pulse in the middle of `eco`, then again in `recupera` -> both ignored, echo width unaffected. Trigger right after holdoff -> accepted.
- Scenario 6: `reset` (or `habilita`=0) asserted mid-echo -> `echo`=0 at the next edge, state 0, no `medida_fim`.
